data_memory_lat: RTL and testbench

- Parametrised line-granular backing store for the L1 data-cache system; replaces the fixed-width, fixed-latency data memory.
- Sits behind the dcache controller on its memory port: enable/write/ack handshake carrying a full cache line.
- Adds over the previous generation: configurable line width, depth and latency, per-word write strobes, request capture, out-of-range error reporting, and an accepted-request counter for bench statistics.

---
 rtl/data_memory_lat.sv | 119 +++++++++++
 tb/tb_data_memory_lat.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_lat.sv
// Line-granular backing store behind the dcache memory port: fixed-latency
// enable/ack handshake, per-word write strobes, range error and request count.
module data_memory_lat #(
  parameter int DATA_W  = 256,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 10,
  parameter int OFF_W   = $clog2(DATA_W/8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/32-1:0]  wstrb_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  busy_o,
  output logic [15:0]           req_cnt_o
);
  localparam int NWORDS = DATA_W / 32;
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam logic [IDX_W-1:0] DEPTH_V  = IDX_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  logic [DATA_W-1:0] memory [DEPTH];

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [NWORDS-1:0]   r_wstrb;
  logic                r_write;
  logic                r_ack, r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [15:0]         r_req_cnt;

  logic                w_accept, w_done, w_in_range;
  logic [MEM_AW-1:0]   w_midx;

  // Full upper-field compare: no aliasing of high address bits onto the array.
  assign w_in_range = (r_idx < DEPTH_V);
  assign w_midx     = r_idx[MEM_AW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (enable_i) begin
        w_accept    = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: if (r_cnt == '0) begin
        w_done      = 1'b1;
        w_state_nxt = ACK;
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_write   <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_req_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx     <= addr_i[ADDR_W-1:OFF_W];
        r_wdata   <= data_i;
        r_wstrb   <= wstrb_i;
        r_write   <= write_i;
        r_cnt     <= CNT_LOAD;
        r_req_cnt <= r_req_cnt + 16'd1;
      end
      if (r_state == BUSY && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_done) begin
        r_ack <= 1'b1;
        r_err <= ~w_in_range;
        if (!r_write)
          r_rdata <= w_in_range ? memory[w_midx] : '0;
      end
      if (r_state == ACK) begin
        r_ack <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  // Array has no reset; a reset edge suppresses the pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_done && r_write && w_in_range)
      for (int n = 0; n < NWORDS; n++)
        if (r_wstrb[n])
          memory[w_midx][32*n +: 32] <= r_wdata[32*n +: 32];
  end

  assign ack_o     = r_ack;
  assign err_o     = r_err;
  assign data_o    = r_rdata;
  assign busy_o    = (r_state != IDLE);
  assign req_cnt_o = r_req_cnt;
endmodule

// File: tb/tb_data_memory_lat.sv
// Directed bench for data_memory_lat: latency, strobes, range errors,
// held-enable behaviour and mid-request reset.
module tb_data_memory_lat;
  localparam int DW = 256;
  localparam int LAT = 10;

  logic          clk_i = 0, rst_i = 1, enable_i = 0, write_i = 0;
  logic [31:0]   addr_i = 0;
  logic [DW-1:0] data_i = 0;
  logic [7:0]    wstrb_i = 0;
  logic          ack_o, err_o, busy_o;
  logic [DW-1:0] data_o;
  logic [15:0]   req_cnt_o;

  data_memory_lat dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .wstrb_i(wstrb_i), .ack_o(ack_o),
    .err_o(err_o), .data_o(data_o), .busy_o(busy_o), .req_cnt_o(req_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;

  localparam logic [DW-1:0] M0   = 256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
  localparam logic [DW-1:0] AAAA = {16{16'hAAAA}};
  localparam logic [DW-1:0] ECFA = {16{16'hECFA}};
  localparam logic [DW-1:0] P16  = {8{32'h1600_0016}};
  localparam logic [DW-1:0] S555 = {16{16'h5555}};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; inputs scrambled right after acceptance to prove capture.
  task automatic txn(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                     input logic [7:0] s, output int lat, output logic e,
                     output logic [DW-1:0] q);
    @(negedge clk_i);
    enable_i = 1; write_i = w; addr_i = a; data_i = d; wstrb_i = s;
    @(posedge clk_i);
    @(negedge clk_i);
    enable_i = 0; write_i = ~w; addr_i = a ^ 32'h0000_0060; data_i = ~d; wstrb_i = ~s;
    lat = 0;
    while (!ack_o && lat < 50) begin
      @(negedge clk_i);
      lat++;
    end
    e = err_o;
    q = data_o;
    @(negedge clk_i);
    chk("ack_pulse", {255'd0, ack_o | busy_o}, '0);
  endtask

  int            lat;
  logic          e;
  logic [DW-1:0] q;
  logic [DW-1:0] snap [512];
  int            diffs, acks, ack_at0, ack_at1;
  logic [DW-1:0] d_at0, d_at1;
  logic [15:0]   rc0;
  logic          busy_gap;

  initial begin
    dut.memory[0]  = M0;
    dut.memory[2]  = ECFA;
    dut.memory[16] = P16;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    chk("rst_ack", {255'd0, ack_o}, '0);
    chk("rst_err", {255'd0, err_o}, '0);
    chk("rst_busy", {255'd0, busy_o}, '0);
    chk("rst_data", data_o, '0);
    chk("rst_cnt", {240'd0, req_cnt_o}, '0);

    // read line 0
    txn(0, 32'h0000, '0, 8'h00, lat, e, q);
    chk("rd0_lat", lat, LAT);
    chk("rd0_err", {255'd0, e}, '0);
    chk("rd0_data", q, M0);
    chk("rd0_cnt", {240'd0, req_cnt_o}, 1);

    // full write line 1, data_o must stay at previous read
    txn(1, 32'h0020, AAAA, 8'hFF, lat, e, q);
    chk("wr1_lat", lat, LAT);
    chk("wr1_err", {255'd0, e}, '0);
    chk("wr1_keep_dout", q, M0);
    chk("wr1_mem", dut.memory[1], AAAA);
    txn(0, 32'h0020, '0, 8'h00, lat, e, q);
    chk("rd1_data", q, AAAA);

    // partial write line 2, low word only
    txn(1, 32'h0040, {224'h1234, 32'hDEADBEEF}, 8'h01, lat, e, q);
    chk("wr2_mem", dut.memory[2], {ECFA[255:32], 32'hDEADBEEF});

    // offset bits ignored
    txn(0, 32'h002C, '0, 8'h00, lat, e, q);
    chk("rd_off", q, AAAA);

    // last line in range, zero-strobe write changes nothing
    txn(1, 32'h3FE0, S555, 8'hFF, lat, e, q);
    chk("wr511_err", {255'd0, e}, '0);
    txn(1, 32'h3FE0, AAAA, 8'h00, lat, e, q);
    txn(0, 32'h3FFF, '0, 8'h00, lat, e, q);
    chk("rd511_data", q, S555);

    // out of range read / write
    for (int i = 0; i < 512; i++) snap[i] = dut.memory[i];
    txn(0, 32'h4000, '0, 8'h00, lat, e, q);
    chk("oor_rd_lat", lat, LAT);
    chk("oor_rd_err", {255'd0, e}, 1);
    chk("oor_rd_data", q, '0);
    txn(1, 32'h4000, AAAA, 8'hFF, lat, e, q);
    chk("oor_wr_err", {255'd0, e}, 1);
    txn(1, 32'h0010_0000, AAAA, 8'hFF, lat, e, q);
    chk("alias_err", {255'd0, e}, 1);
    diffs = 0;
    for (int i = 0; i < 512; i++) if (dut.memory[i] !== snap[i]) diffs++;
    chk("oor_nochg", diffs, 0);

    // enable held high; address changes during BUSY
    rc0 = req_cnt_o;
    acks = 0; ack_at0 = -1; ack_at1 = -1; d_at0 = '0; d_at1 = '0; busy_gap = 1;
    @(negedge clk_i);
    enable_i = 1; write_i = 0; addr_i = 32'h0020;
    @(posedge clk_i);
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk_i);
      if (i == 0) addr_i = 32'h0200;
      if (i == 11) busy_gap = busy_o;
      if (i == 12) enable_i = 0;
      if (ack_o) begin
        if (acks == 0) begin ack_at0 = i; d_at0 = data_o; end
        else if (acks == 1) begin ack_at1 = i; d_at1 = data_o; end
        acks++;
      end
    end
    chk("hold_acks", acks, 2);
    chk("hold_ack0_at", ack_at0, 10);
    chk("hold_ack0_data", d_at0, AAAA);
    chk("hold_gap_busy", {255'd0, busy_gap}, '0);
    chk("hold_ack1_at", ack_at1, 22);
    chk("hold_ack1_data", d_at1, P16);
    chk("hold_cnt", {240'd0, req_cnt_o - rc0}, 2);

    // reset at cycle 5 of a write to line 0
    @(negedge clk_i);
    enable_i = 1; write_i = 1; addr_i = 32'h0000; data_i = '0; wstrb_i = 8'hFF;
    @(posedge clk_i);
    @(negedge clk_i);
    enable_i = 0;
    repeat (4) @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
    chk("mrst_busy", {255'd0, busy_o}, '0);
    chk("mrst_cnt", {240'd0, req_cnt_o}, '0);
    rst_i = 0;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    chk("mrst_noack", acks, 0);
    chk("mrst_mem0", dut.memory[0], M0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
